memory_dump_reader: RTL and testbench
=====================================

Name: memory_dump_reader

Overview:
Debug-side reader for the data memory's debug read port.
- On a start request it walks every word address from 0 to N_ADDRESS_WORDS-1 through the debug port.
- It serializes each 32-bit word into 4 bytes, least-significant byte first, onto a valid/ready byte stream.
- The byte stream feeds the debug UART transmitter, so the host receives a full data-memory dump.

Parameters:
- NB_DATA_BUS, 32, data memory word width (fixed at 32; 4 bytes per word).
- N_ADDRESS, 128, data memory size in bytes.
- N_ADDRESS_WORDS, N_ADDRESS/4, number of words dumped.
- NB_ADDRESS_WORDS, $clog2(N_ADDRESS_WORDS), debug word-address width.
- NB_BYTE, 8, byte stream width.

Ports:
- i_clk  in  1  system clock; rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start-dump request; sampled only in IDLE.
- o_busy  out  1  high from the cycle after start is accepted until DONE exits.
- o_done  out  1  one-cycle pulse when the final byte has been accepted.
- o_d_en  out  1  debug read enable to the data memory.
- o_d_addr  out  NB_ADDRESS_WORDS  debug word address.
- i_d_r_data  in  NB_DATA_BUS  debug read data; valid exactly 1 cycle after o_d_en=1.
- o_tx_data  out  NB_BYTE  byte to the transmitter.
- o_tx_valid  out  1  byte valid.
- i_tx_ready  in  1  transmitter accepts the byte when valid&ready at a rising edge.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - state=IDLE.
  - o_busy=0, o_done=0, o_d_en=0, o_d_addr=0, o_tx_valid=0, o_tx_data=0.
  - word counter, byte counter and shift register all cleared.
  - Reset mid-dump aborts immediately; no partial byte is held afterwards.
- All outputs are registered.
- States:
  - IDLE: if i_start=1, clear word_cnt, set o_busy=1 -> REQ.
  - REQ: o_d_en=1, o_d_addr=word_cnt for exactly one cycle -> CAPT.
  - CAPT: o_d_en=0; load shift_reg<=i_d_r_data, byte_cnt<=0 -> SEND.
  - SEND: o_tx_valid=1, o_tx_data=shift_reg[7:0].
    - On valid&ready: shift_reg>>=8 and byte_cnt++.
    - If byte_cnt was 3 and word_cnt==N_ADDRESS_WORDS-1 -> DONE.
    - If byte_cnt was 3 otherwise: word_cnt++ -> REQ.
    - Otherwise stay in SEND and present the next byte in the following cycle.
  - DONE: o_done=1 for one cycle, o_tx_valid=0 -> IDLE. o_busy falls on leaving DONE.
- Handshake rules:
  - Once o_tx_valid rises, o_tx_valid and o_tx_data hold stable until accepted.
  - o_tx_valid never depends combinationally on i_tx_ready.
  - i_tx_ready held high gives one byte per cycle inside a word.
  - Each word costs 2 extra cycles (REQ, CAPT).
  - Minimum dump time with ready=1: N_ADDRESS_WORDS*6 + 2 cycles from start acceptance to the o_done pulse.
- i_start while not in IDLE is ignored; no queuing.
- i_start held high across DONE->IDLE restarts a new dump.
- Word counter reaches its last value without wrap; no address beyond N_ADDRESS_WORDS-1 is ever issued.
- o_d_en is never asserted outside REQ, so the debug port is idle otherwise.
- Byte order per word: [7:0], [15:8], [23:16], [31:24], matching the memory byte lanes (addr[1:0]=0..3).

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum (mod 256) of every byte accepted is kept and cleared on start.
  - After the last data byte, the FSM enters CKSUM instead of DONE and presents the sum with the same valid/ready rules.
  - On acceptance -> DONE.
  - The dump is N_ADDRESS+1 bytes.
- Not defined:
  - No CKSUM state and no sum register.
  - The dump is exactly N_ADDRESS bytes.

Decomposition:
- Shared package memory_dump_pkg:
  - state encoding localparams: IDLE, REQ, CAPT, SEND, CKSUM, DONE (3 bits).
  - BYTES_PER_WORD=4.
  - NB_BYTE=8.
- One natural sub-module, word_byte_serializer: loads a 32-bit word and emits 4 bytes LSB-first under valid/ready, returning a last_byte_accepted strobe. The top-level FSM owns addressing and done/checksum.

Test Plan:
- Memory preloaded word[k]=32'h03020100+k*32'h04040404, ready=1, start pulse -> 128 bytes 0x00..0x7F in order; o_done pulse at cycle 194 after start accepted; o_d_addr sequence 0..31 with one o_d_en cycle each.
- word[0]=32'hDEADBEEF, ready toggling 1/0 every cycle -> bytes EF,BE,AD,DE; o_tx_data stable while valid&!ready; no byte lost or duplicated.
- Reset asserted while in SEND at byte 2 of word 5 -> all outputs 0 asynchronously; after release, a new start dumps again from word 0.
- i_start pulsed while busy (word 10) -> ignored; exactly 128 bytes and one o_done; start held high through DONE -> second dump begins at address 0.
- DUMP_CHECKSUM_EN defined, all words 32'h01010101 -> 128 bytes of 0x01, then a checksum byte 0x80, then o_done.
- ready=0 for 50 cycles at the first byte -> FSM stays in SEND, o_d_en stays 0, o_busy=1, no address advance.

Source files
------------

// File: rtl/memory_dump_reader_pkg.sv
// Shared types and constants for the data-memory dump reader.
package memory_dump_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int NB_BYTE        = 8;
    localparam int NB_BYTE_CNT    = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        CAPT  = 3'd2,
        SEND  = 3'd3,
        CKSUM = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/memory_dump_reader_if.sv
// Control, debug-read and byte-stream signals of the dump reader.
interface memory_dump_reader_if #(
    parameter int NB_DATA_BUS      = 32,
    parameter int NB_ADDRESS_WORDS = 5,
    parameter int NB_BYTE          = 8
);
    logic                        i_start;
    logic                        o_busy;
    logic                        o_done;
    logic                        o_d_en;
    logic [NB_ADDRESS_WORDS-1:0] o_d_addr;
    logic [NB_DATA_BUS-1:0]      i_d_r_data;
    logic [NB_BYTE-1:0]          o_tx_data;
    logic                        o_tx_valid;
    logic                        i_tx_ready;

    modport master (
        input  i_start, i_d_r_data, i_tx_ready,
        output o_busy, o_done, o_d_en, o_d_addr, o_tx_data, o_tx_valid
    );

    modport slave (
        output i_start, i_d_r_data, i_tx_ready,
        input  o_busy, o_done, o_d_en, o_d_addr, o_tx_data, o_tx_valid
    );
endinterface

// File: rtl/memory_dump_reader_serializer.sv
// Loads a word and emits its bytes LSB-first on a registered valid/ready stream.
module word_byte_serializer
    import memory_dump_pkg::*;
#(
    parameter int NB_WORD = BYTES_PER_WORD * NB_BYTE
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_load,
    input  logic [NB_WORD-1:0]     i_word,
    input  logic [NB_BYTE_CNT-1:0] i_last_idx,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [NB_BYTE-1:0]     o_data,
    output logic                   o_last_acc
);
    logic [NB_WORD-1:0]     shift_q, shift_d;
    logic [NB_BYTE_CNT-1:0] cnt_q, cnt_d;
    logic [NB_BYTE_CNT-1:0] last_idx_q, last_idx_d;
    logic                   valid_q, valid_d;
    logic                   accept;

    assign accept     = valid_q & i_ready;
    assign o_last_acc = accept && (cnt_q == last_idx_q);
    assign o_valid    = valid_q;
    assign o_data     = shift_q[NB_BYTE-1:0];

    // A load wins over an acceptance so the next word can follow the last byte back-to-back.
    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        last_idx_d = last_idx_q;
        valid_d    = valid_q;
        if (i_load) begin
            shift_d    = i_word;
            cnt_d      = '0;
            last_idx_d = i_last_idx;
            valid_d    = 1'b1;
        end else if (accept) begin
            shift_d = shift_q >> NB_BYTE;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == last_idx_q) valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q    <= '0;
            cnt_q      <= '0;
            last_idx_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            last_idx_q <= last_idx_d;
            valid_q    <= valid_d;
        end
    end

endmodule

// File: rtl/memory_dump_reader.sv
// Walks the data memory through the debug port and streams it out byte by byte.
// Define DUMP_CHECKSUM_EN to append an 8-bit running sum byte after the data.
module memory_dump_reader
    import memory_dump_pkg::*;
#(
    parameter int NB_DATA_BUS      = 32,
    parameter int N_ADDRESS        = 128,
    parameter int N_ADDRESS_WORDS  = N_ADDRESS / 4,
    parameter int NB_ADDRESS_WORDS = $clog2(N_ADDRESS_WORDS)
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    memory_dump_reader_if.master bus
);
    localparam logic [NB_ADDRESS_WORDS-1:0] LAST_WORD = NB_ADDRESS_WORDS'(N_ADDRESS_WORDS - 1);

    state_t                      state_q, state_d;
    logic [NB_ADDRESS_WORDS-1:0] word_cnt_q, word_cnt_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        d_en_q, d_en_d;

    logic                        ser_load;
    logic [NB_DATA_BUS-1:0]      ser_word;
    logic [NB_BYTE_CNT-1:0]      ser_last_idx;
    logic                        ser_valid;
    logic [NB_BYTE-1:0]          ser_data;
    logic                        ser_last_acc;

`ifdef DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0]          sum_q, sum_d, sum_acc;
    assign sum_acc = sum_q + ser_data;
`endif

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        d_en_d       = 1'b0;
        ser_load     = 1'b0;
        ser_word     = bus.i_d_r_data;
        ser_last_idx = NB_BYTE_CNT'(BYTES_PER_WORD - 1);
`ifdef DUMP_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        case (state_q)
            IDLE: if (bus.i_start) begin
                word_cnt_d = '0;
                busy_d     = 1'b1;
                d_en_d     = 1'b1;
                state_d    = REQ;
`ifdef DUMP_CHECKSUM_EN
                sum_d      = '0;
`endif
            end
            REQ:  state_d = CAPT;
            CAPT: begin
                ser_load = 1'b1;
                state_d  = SEND;
            end
            SEND: begin
`ifdef DUMP_CHECKSUM_EN
                if (ser_valid && bus.i_tx_ready) sum_d = sum_acc;
`endif
                if (ser_last_acc) begin
                    if (word_cnt_q == LAST_WORD) begin
`ifdef DUMP_CHECKSUM_EN
                        // Sum already includes the byte accepted on this edge.
                        ser_load     = 1'b1;
                        ser_word     = {{(NB_DATA_BUS-NB_BYTE){1'b0}}, sum_acc};
                        ser_last_idx = '0;
                        state_d      = CKSUM;
`else
                        done_d  = 1'b1;
                        state_d = DONE;
`endif
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        d_en_d     = 1'b1;
                        state_d    = REQ;
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            CKSUM: if (ser_last_acc) begin
                done_d  = 1'b1;
                state_d = DONE;
            end
`endif
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            d_en_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            d_en_q     <= d_en_d;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sum_q <= '0;
        else          sum_q <= sum_d;
    end
`endif

    word_byte_serializer #(.NB_WORD(NB_DATA_BUS)) u_ser (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (ser_load),
        .i_word     (ser_word),
        .i_last_idx (ser_last_idx),
        .i_ready    (bus.i_tx_ready),
        .o_valid    (ser_valid),
        .o_data     (ser_data),
        .o_last_acc (ser_last_acc)
    );

    assign bus.o_busy     = busy_q;
    assign bus.o_done     = done_q;
    assign bus.o_d_en     = d_en_q;
    assign bus.o_d_addr   = word_cnt_q;
    assign bus.o_tx_valid = ser_valid;
    assign bus.o_tx_data  = ser_data;

endmodule

// File: tb/tb_memory_dump_reader.sv
// Bench for memory_dump_reader: byte-queue reference model, table of dump scenarios, corner sequences.
module tb_memory_dump_reader;
    import memory_dump_pkg::*;

    localparam int N_ADDRESS = 128;
    localparam int NW        = N_ADDRESS / 4;
    localparam int NBA       = $clog2(NW);
`ifdef DUMP_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int FULL_CYC = NW * 6 + 2 + CK;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    memory_dump_reader_if #(.NB_DATA_BUS(32), .NB_ADDRESS_WORDS(NBA), .NB_BYTE(8)) bus ();

    memory_dump_reader #(.NB_DATA_BUS(32), .N_ADDRESS(N_ADDRESS)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Memory with one-cycle read latency; garbage on the bus when not reading.
    logic [31:0] mem [NW];
    always @(posedge clk) bus.i_d_r_data <= bus.o_d_en ? mem[bus.o_d_addr] : $urandom();

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int exp_len, nacc, ndone, next_addr;
    bit prev_stall, prev_den;
    logic [7:0] prev_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < NW; k++) begin
            case (mode)
                0:       mem[k] = 32'h03020100 + k * 32'h04040404;
                1:       mem[k] = (k == 0) ? 32'hDEADBEEF : $urandom();
                3:       mem[k] = 32'h01010101;
                default: mem[k] = $urandom();
            endcase
        end
    endtask

    // Reference: the dump is every word's bytes, low byte first, plus optional sum.
    task automatic build_exp();
        logic [7:0] sum;
        logic [7:0] b;
        exp_q.delete();
        sum = 8'h00;
        for (int k = 0; k < NW; k++)
            for (int j = 0; j < 4; j++) begin
                b = mem[k][8*j +: 8];
                exp_q.push_back(b);
                sum = sum + b;
            end
        if (CK != 0) exp_q.push_back(sum);
        exp_len   = exp_q.size();
        nacc      = 0;
        ndone     = 0;
        next_addr = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_den   = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", bus.o_tx_valid, 1);
                chk("hold_data", bus.o_tx_data, prev_data);
            end
            if (bus.o_tx_valid && bus.i_tx_ready) begin
                if (exp_q.size() == 0) chk("extra_byte", nacc + 1, exp_len);
                else                   chk("byte", bus.o_tx_data, exp_q.pop_front());
                nacc++;
            end
            if (bus.o_d_en) begin
                chk("addr", bus.o_d_addr, next_addr);
                chk("den_single", prev_den, 0);
                chk("den_busy", bus.o_busy, 1);
                chk("den_no_tx", bus.o_tx_valid, 0);
                next_addr++;
            end
            if (bus.o_done) begin
                ndone++;
                chk("done_txv", bus.o_tx_valid, 0);
                chk("done_left", exp_q.size(), 0);
            end
            prev_stall = bus.o_tx_valid && !bus.i_tx_ready;
            prev_data  = bus.o_tx_data;
            prev_den   = bus.o_d_en;
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  bus.o_busy, 0);
        chk({tag, "_done"},  bus.o_done, 0);
        chk({tag, "_den"},   bus.o_d_en, 0);
        chk({tag, "_addr"},  bus.o_d_addr, 0);
        chk({tag, "_txv"},   bus.o_tx_valid, 0);
        chk({tag, "_txd"},   bus.o_tx_data, 0);
    endtask

    // rdy_mode: 0 always ready, 1 toggle, 2 random, 3 stall 50 cycles at first byte.
    task automatic run_dump(input int rdy_mode, input int exp_cyc, input int poke_addr, input bit hold_start);
        int c;
        int stall;
        bit seen;
        build_exp();
        @(negedge clk);
        bus.i_start    = 1'b1;
        bus.i_tx_ready = (rdy_mode == 3) ? 1'b0 : 1'b1;
        c = 1; stall = 0; seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(posedge clk);
            c++;
            #1;
            if (!hold_start) bus.i_start = 1'b0;
            if (poke_addr >= 0 && bus.o_busy && bus.o_d_addr == poke_addr) bus.i_start = 1'b1;
            case (rdy_mode)
                0: bus.i_tx_ready = 1'b1;
                1: bus.i_tx_ready = ~bus.i_tx_ready;
                2: bus.i_tx_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (stall < 50) begin
                        bus.i_tx_ready = 1'b0;
                        if (bus.o_tx_valid) begin
                            stall++;
                            chk("stall_den", bus.o_d_en, 0);
                            chk("stall_busy", bus.o_busy, 1);
                            chk("stall_addr", bus.o_d_addr, 0);
                        end
                    end else bus.i_tx_ready = 1'b1;
                end
            endcase
            @(negedge clk);
            if (bus.o_done) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
        if (exp_cyc > 0) chk("dump_cycles", c, exp_cyc);
        chk("byte_count", nacc, exp_len);
        if (!hold_start) begin
            repeat (4) @(negedge clk);
            chk("done_once", ndone, 1);
            chk("busy_after", bus.o_busy, 0);
            chk("words_issued", next_addr, NW);
        end
    endtask

    typedef struct {
        int fill;
        int rdy;
        int cyc;
    } vec_t;

    vec_t tbl[5];
    bit   hit;

    initial begin
        bus.i_start    = 1'b0;
        bus.i_tx_ready = 1'b0;
        fill(0);
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = '{0, 0, FULL_CYC};
        tbl[1] = '{1, 1, 0};
        tbl[2] = '{2, 2, 0};
        tbl[3] = '{3, 0, FULL_CYC};
        tbl[4] = '{0, 3, FULL_CYC + 50};
        for (int t = 0; t < 5; t++) begin
            fill(tbl[t].fill);
            run_dump(tbl[t].rdy, tbl[t].cyc, -1, 1'b0);
        end

        // Abort with reset while word 5 byte 2 is on the stream.
        fill(0);
        build_exp();
        @(negedge clk);
        bus.i_start    = 1'b1;
        bus.i_tx_ready = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(posedge clk);
            #1;
            bus.i_start = 1'b0;
            if (bus.o_tx_valid && bus.o_tx_data == 8'h16) begin
                bus.i_tx_ready = 1'b0;
                hit = 1'b1;
            end
        end
        chk("reach_w5b2", hit, 1);
        chk("pre_rst_addr", bus.o_d_addr, 5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_dump(0, FULL_CYC, -1, 1'b0);

        // Start pulses during word 10 must be ignored.
        fill(2);
        run_dump(0, FULL_CYC, 10, 1'b0);

        // Start held through DONE restarts from address 0.
        fill(0);
        run_dump(0, FULL_CYC, -1, 1'b1);
        next_addr = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("restart_den", bus.o_d_en, 1);
        chk("restart_addr", bus.o_d_addr, 0);
        chk("restart_busy", bus.o_busy, 1);
        bus.i_start = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
